fs_accel_obuf_seq: RTL and testbench
====================================

// Module: fs_accel_obuf_seq
// PURPOSE
//  Sequencer for the accelerator output buffer. Per job it accepts NUM result words
//  from the compute datapath (valid/ready) and loads each into the 32-bit obuf.
//  It then writes each word to memory at consecutive addresses over a valid/ready port.
//  Sits between the PE array result path, the obuf register and the core memory bus.
// PARAMETERS
//  ADDR_W     32  memory address width
//  CNT_W      16  job word-count width
//  ADDR_STEP  4   address increment per word (bytes)
// PORTS
//  clk          in   1       clock
//  resetn       in   1       synchronous active-low reset
//  start        in   1       job start pulse (sampled only in IDLE)
//  base_addr    in   ADDR_W  first write address of job
//  num_words    in   CNT_W   words in job
//  busy         out  1       high in any state other than IDLE
//  done         out  1       1-cycle job-complete pulse
//  res_valid    in   1       datapath result valid
//  res_data     in   32      datapath result word
//  res_ready    out  1       result accepted when valid&ready
//  obuf_di      out  32      data to obuf
//  obuf_ld_wrn  out  1       obuf load strobe (1 = load)
//  obuf_enb     out  1       obuf enable
//  obuf_do      in   32      obuf registered output
//  mem_valid    out  1       memory write request
//  mem_ready    in   1       memory write accepted
//  mem_addr     out  ADDR_W  write address
//  mem_wdata    out  32      write data (= obuf_do)
// BEHAVIOUR
//  Reset: clock clk; reset resetn, synchronous, active-low. Reset forces state IDLE.
//   Reset drives busy=done=res_ready=obuf_enb=obuf_ld_wrn=mem_valid=0.
//   Reset clears the address and count registers to 0. A reset mid-job abandons any
//   pending mem write, and no done pulse is produced.
//  FSM states: IDLE, CAPT, WRITE, DONE.
//  IDLE: on start with num_words!=0, latch base_addr->cur_addr and num_words->remain,
//   then go to CAPT.
//   On start with num_words==0, go to DONE (done pulses next cycle; no bus traffic).
//  CAPT: res_ready=1.
//   On res_valid: obuf_enb=1, obuf_ld_wrn=1, obuf_di=res_data (combinational, same
//   cycle). The obuf captures on that edge. Then go to WRITE.
//   Outside this handshake cycle, obuf_enb=obuf_ld_wrn=0 and obuf_di=0.
//  WRITE: mem_valid=1, mem_addr=cur_addr, mem_wdata=obuf_do. All are held stable
//   until mem_ready. res_ready=0.
//   On mem_ready: cur_addr+=ADDR_STEP (wraps mod 2^ADDR_W) and remain-=1.
//   Then go to DONE if remain==1, else to CAPT.
//  DONE: done=1 for exactly one cycle, then go to IDLE.
//  busy=1 in CAPT, WRITE and DONE.
//  start is ignored while busy. base_addr/num_words are sampled only at accepted start.
//  Throughput: min 2 cycles/word (CAPT + WRITE with mem_ready=1); per-job latency
//   from start to done is 2*N+1 cycles minimum.
//  Backpressure: res_valid low stalls in CAPT; mem_ready low stalls in WRITE.
//   Neither stall loses data.
//  num_words = 2^CNT_W-1 must complete; the count never underflows.
// CONFIGURATION
//  FS_OBUF_RELU_EN defined: the obuf_di path applies ReLU.
//   If res_data[31]==1 then obuf_di=0, else obuf_di=res_data.
//   mem_wdata therefore never has bit 31 set.
//  Undefined: obuf_di=res_data unmodified.
// TESTING
//  T1 base=0x1000,N=3,res=0x11,0x22,0x33, res_valid/mem_ready=1 -> writes 0x1000/0x11,
//   0x1004/0x22, 0x1008/0x33; done 7 cycles after start.
//  T2 N=0 start -> done pulse next cycle; mem_valid, res_ready never asserted.
//  T3 N=2, mem_ready low 5 cycles in first WRITE -> mem_addr/mem_wdata stable,
//   res_ready=0 throughout; 2 writes total.
//  T4 base=0xFFFFFFFC,N=2 -> addresses 0xFFFFFFFC then 0x00000000.
//  T5 resetn low during WRITE of word 2 of N=4 -> next cycle IDLE, all outputs 0,
//   no done; new job N=1 then runs normally.
//  T6 res=0xFFFFFFF0 -> wdata 0x00000000 with FS_OBUF_RELU_EN,
//   0xFFFFFFF0 without; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/fs_accel_obuf_seq_if.sv
// Bus bundle for the output-buffer sequencer: result stream in, obuf load port, memory write port.
// No latency of its own; pure wiring between the sequencer and its neighbours.
// Backpressure: res_valid/res_ready and mem_valid/mem_ready are standard valid/ready pairs.
interface fs_accel_obuf_seq_if #(
    parameter int ADDR_W = 32
);
    // Result stream from the PE array
    logic              res_valid;
    logic [31:0]       res_data;
    logic              res_ready;

    // obuf register port
    logic [31:0]       obuf_di;
    logic              obuf_ld_wrn;
    logic              obuf_enb;
    logic [31:0]       obuf_do;

    // Memory write port
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Sequencer side
    modport master (
        input  res_valid,
        input  res_data,
        output res_ready,
        output obuf_di,
        output obuf_ld_wrn,
        output obuf_enb,
        input  obuf_do,
        output mem_valid,
        input  mem_ready,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: datapath, obuf register and memory bus
    modport slave (
        output res_valid,
        output res_data,
        input  res_ready,
        input  obuf_di,
        input  obuf_ld_wrn,
        input  obuf_enb,
        output obuf_do,
        input  mem_valid,
        output mem_ready,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/fs_accel_obuf_seq.sv
// Output-buffer sequencer: per job, captures NUM result words into the obuf and writes each
// to consecutive memory addresses. 2 cycles/word minimum, start-to-done 2*N+1 cycles minimum.
// Backpressure: res_valid low stalls in CAPT, mem_ready low stalls in WRITE; nothing is dropped.
// Optional macro FS_OBUF_RELU_EN: clamp negative result words to zero on the obuf load path.
module fs_accel_obuf_seq #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          num_words,
    output logic                      busy,
    output logic                      done,
    fs_accel_obuf_seq_if.master       bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CAPT  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [CNT_W-1:0]  ONE  = CNT_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remain;
    logic [31:0]       load_dat;

    // Data presented to the obuf; optionally rectified so negative words store as zero
`ifdef FS_OBUF_RELU_EN
    assign load_dat = bus.res_data[31] ? 32'h0000_0000 : bus.res_data;
`else
    assign load_dat = bus.res_data;
`endif

    // Job sequencing: state, running address and words-left counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            cur_addr <= base_addr;
                            remain   <= num_words;
                            state    <= CAPT;
                        end else begin
                            // Empty job: report completion without touching either bus
                            state <= DONE;
                        end
                    end
                end
                CAPT: begin
                    if (bus.res_valid) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        cur_addr <= cur_addr + STEP;
                        remain   <= remain - ONE;
                        // Decide on the pre-decrement value so remain never goes below zero
                        state    <= (remain == ONE) ? DONE : CAPT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs decoded from state; the obuf load strobe follows the result handshake
    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        bus.res_ready   = 1'b0;
        bus.obuf_enb    = 1'b0;
        bus.obuf_ld_wrn = 1'b0;
        bus.obuf_di     = 32'h0000_0000;
        bus.mem_valid   = 1'b0;
        bus.mem_addr    = cur_addr;
        bus.mem_wdata   = bus.obuf_do;
        case (state)
            CAPT: begin
                bus.res_ready = 1'b1;
                if (bus.res_valid) begin
                    bus.obuf_enb    = 1'b1;
                    bus.obuf_ld_wrn = 1'b1;
                    bus.obuf_di     = load_dat;
                end
            end
            WRITE: begin
                bus.mem_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fs_accel_obuf_seq.sv
// Bench for fs_accel_obuf_seq: models the obuf register and memory, scoreboards writes.
// Expected writes are queued at job start and popped on each mem handshake.
module tb_fs_accel_obuf_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic [31:0] obuf_q;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] wdat [0:7];

    fs_accel_obuf_seq_if #(.ADDR_W(32)) bif ();

    fs_accel_obuf_seq #(.ADDR_W(32), .CNT_W(16), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // obuf register model: loads when enabled with the load strobe
    initial obuf_q = 32'h0;
    always @(posedge clk) begin
        if (bif.obuf_enb && bif.obuf_ld_wrn) obuf_q <= bif.obuf_di;
    end
    assign bif.obuf_do = obuf_q;

    function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef FS_OBUF_RELU_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    // Runs one job; inputs change at negedge, outputs sampled 3 time units later.
    task automatic do_job(input logic [31:0] base, input logic [15:0] n,
                          input int stall_word, input int stall_len, input int abort_word,
                          input bit rnd, input bit busy_start, output int done_cyc);
        int cyc = 0;
        int ridx = 0;
        int widx = 0;
        int stall_left = stall_len;
        bit held = 0;
        bit fin = 0;
        logic [31:0] h_addr = 0;
        logic [31:0] h_data = 0;
        logic [31:0] ea, ed;
        done_cyc = -1;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(base + 32'(i) * 32'd4);
            exp_data.push_back(relu(wdat[i % 8]));
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = n;
        bif.res_valid = 1'b0; bif.mem_ready = 1'b1;
        while (!fin) begin
            if (cyc > 0) begin
                start = busy_start && (cyc == 2);
                if (start) begin base_addr = 32'hDEAD_0000; num_words = 16'd5; end
                bif.res_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bif.res_data  = wdat[ridx % 8];
                if (bif.mem_valid && widx == stall_word && stall_left > 0) begin
                    bif.mem_ready = 1'b0; stall_left--;
                end else begin
                    bif.mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bif.mem_valid && widx == abort_word) resetn = 1'b0;
            end
            #3;
            if (!resetn) begin
                @(negedge clk);
                resetn = 1'b1; start = 1'b0; bif.res_valid = 1'b0; bif.mem_ready = 1'b0;
                #3;
                total++;
                if ({busy, done, bif.res_ready, bif.obuf_enb, bif.obuf_ld_wrn, bif.mem_valid} !== 6'b0
                    || bif.mem_addr !== 32'h0 || bif.obuf_di !== 32'h0) begin
                    bad++;
                    $display("FAIL abort_outputs: busy=%b done=%b rrdy=%b enb=%b ld=%b mv=%b addr=%h di=%h, all should be 0",
                             busy, done, bif.res_ready, bif.obuf_enb, bif.obuf_ld_wrn, bif.mem_valid,
                             bif.mem_addr, bif.obuf_di);
                end
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk); #3;
                    total++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        bad++;
                        $display("FAIL abort_no_done: done=%b busy=%b, expected 0 0", done, busy);
                    end
                end
                exp_addr.delete(); exp_data.delete();
                return;
            end
            if (bif.res_valid && bif.res_ready) begin
                total++;
                if (bif.obuf_enb !== 1'b1 || bif.obuf_ld_wrn !== 1'b1 || bif.obuf_di !== relu(bif.res_data)) begin
                    bad++;
                    $display("FAIL obuf_load: enb=%b ld=%b di=%h, expected 1 1 %h",
                             bif.obuf_enb, bif.obuf_ld_wrn, bif.obuf_di, relu(bif.res_data));
                end
                ridx++;
            end else begin
                total++;
                if (bif.obuf_enb !== 1'b0 || bif.obuf_ld_wrn !== 1'b0 || bif.obuf_di !== 32'h0) begin
                    bad++;
                    $display("FAIL obuf_idle: enb=%b ld=%b di=%h, expected 0 0 0",
                             bif.obuf_enb, bif.obuf_ld_wrn, bif.obuf_di);
                end
            end
            if (n == 0) begin
                total++;
                if (bif.mem_valid !== 1'b0 || bif.res_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL empty_job_bus: mv=%b rrdy=%b, expected 0 0", bif.mem_valid, bif.res_ready);
                end
            end
            if (bif.mem_valid === 1'b1) begin
                total++;
                if (bif.res_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL write_res_ready: res_ready=%b, expected 0", bif.res_ready);
                end
                if (held) begin
                    total++;
                    if (bif.mem_addr !== h_addr || bif.mem_wdata !== h_data) begin
                        bad++;
                        $display("FAIL stall_stable: addr=%h data=%h, held %h %h",
                                 bif.mem_addr, bif.mem_wdata, h_addr, h_data);
                    end
                end
                if (bif.mem_ready) begin
                    total++;
                    if (exp_addr.size() == 0) begin
                        bad++;
                        $display("FAIL extra_write: addr=%h data=%h, no write expected", bif.mem_addr, bif.mem_wdata);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        if (bif.mem_addr !== ea || bif.mem_wdata !== ed) begin
                            bad++;
                            $display("FAIL write%0d: addr=%h data=%h, expected %h %h",
                                     widx, bif.mem_addr, bif.mem_wdata, ea, ed);
                        end
                    end
                    widx++;
                    held = 0;
                end else begin
                    held = 1; h_addr = bif.mem_addr; h_data = bif.mem_wdata;
                end
            end else begin
                held = 0;
            end
            if (done === 1'b1) begin
                done_cyc = cyc; fin = 1;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_busy: busy=%b during done, expected 1", busy);
                end
            end
            if (cyc > 400) begin
                bad++;
                $display("FAIL timeout: no done after %0d cycles", cyc);
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bif.res_valid = 1'b0;
        #3;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || exp_addr.size() != 0) begin
            bad++;
            $display("FAIL job_end: busy=%b done=%b pending=%0d, expected 0 0 0", busy, done, exp_addr.size());
        end
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; base_addr = 32'h0; num_words = 16'h0;
        bif.res_valid = 1'b1; bif.res_data = 32'h5; bif.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        total++;
        if ({busy, done, bif.res_ready, bif.obuf_enb, bif.obuf_ld_wrn, bif.mem_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b rrdy=%b enb=%b ld=%b mv=%b, expected all 0",
                     busy, done, bif.res_ready, bif.obuf_enb, bif.obuf_ld_wrn, bif.mem_valid);
        end
        @(negedge clk);
        resetn = 1'b1; bif.res_valid = 1'b0;
    endtask

    task automatic test_basic();
        int dc;
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33;
        do_job(32'h1000, 16'd3, -1, 0, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 7) begin bad++; $display("FAIL basic_latency: done at %0d, expected 7", dc); end
    endtask

    task automatic test_zero();
        int dc;
        do_job(32'h2000, 16'd0, -1, 0, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 1) begin bad++; $display("FAIL zero_latency: done at %0d, expected 1", dc); end
    endtask

    task automatic test_stall();
        int dc;
        wdat[0] = 32'hA5A5_0001; wdat[1] = 32'h0BAD_0002;
        do_job(32'h3000, 16'd2, 0, 5, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 10) begin bad++; $display("FAIL stall_latency: done at %0d, expected 10", dc); end
    endtask

    task automatic test_wrap();
        int dc;
        wdat[0] = 32'h0000_0AAA; wdat[1] = 32'h0000_0BBB;
        do_job(32'hFFFF_FFFC, 16'd2, -1, 0, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 5) begin bad++; $display("FAIL wrap_latency: done at %0d, expected 5", dc); end
    endtask

    task automatic test_reset_mid();
        int dc;
        for (int i = 0; i < 4; i++) wdat[i] = 32'h100 + 32'(i);
        do_job(32'h4000, 16'd4, -1, 0, 1, 1'b0, 1'b0, dc);
        wdat[0] = 32'h0000_7777;
        do_job(32'h5000, 16'd1, -1, 0, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 3) begin bad++; $display("FAIL post_reset_latency: done at %0d, expected 3", dc); end
    endtask

    task automatic test_relu_busy();
        int dc;
        wdat[0] = 32'hFFFF_FFF0; wdat[1] = 32'h7FFF_FFFF;
        do_job(32'h6000, 16'd2, -1, 0, -1, 1'b0, 1'b1, dc);
        total++;
        if (dc != 5) begin bad++; $display("FAIL busy_start_latency: done at %0d, expected 5", dc); end
    endtask

    task automatic test_random();
        int dc;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 8; i++) wdat[i] = $urandom;
            do_job($urandom & 32'hFFFF_FFFC, 16'd8, -1, 0, -1, 1'b1, 1'b0, dc);
            total++;
            if (dc < 17) begin bad++; $display("FAIL random_latency: done at %0d, expected >= 17", dc); end
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        wdat[0] = 32'hCAFE_0000; wdat[1] = 32'h1234_5678; wdat[2] = 32'h8000_0001;
        do_job(32'h7000, 16'd3, -1, 0, -1, 1'b0, 1'b0, dc);
        do_job(32'h8000, 16'd3, -1, 0, -1, 1'b0, 1'b0, dc);
        total++;
        if (dc != 7) begin bad++; $display("FAIL b2b_latency: done at %0d, expected 7", dc); end
    endtask

    initial begin
        bif.res_data = 32'h0;
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_relu_busy();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
